// File: rtl/comparator_4bit_pkg.sv
// Shared definitions for the registered 4-bit unsigned magnitude comparator.
// The result encoding is one-hot {LT, GT, EQ}; CMP_NONE marks "no result yet".
package comparator_4bit_pkg;

    localparam int WIDTH = 4;

    typedef logic [2:0] cmp_result_t;

    localparam cmp_result_t CMP_NONE = 3'b000;
    localparam cmp_result_t CMP_EQ   = 3'b001;
    localparam cmp_result_t CMP_GT   = 3'b010;
    localparam cmp_result_t CMP_LT   = 3'b100;

endpackage

// File: rtl/comparator_4bit_cmp_bit_slice.sv
// One stage of the MSB-first magnitude cascade. Once an upstream stage has
// decided GT or LT, the decision passes through untouched; otherwise the
// first differing bit here settles it.
module cmp_bit_slice (
    input  logic a,
    input  logic b,
    input  logic eq_i,
    input  logic gt_i,
    input  logic lt_i,
    output logic eq_o,
    output logic gt_o,
    output logic lt_o
);

    // Resolve this bit only while every more significant bit has matched.
    always_comb begin
        eq_o = eq_i & ~(a ^ b);
        gt_o = gt_i | (eq_i & a & ~b);
        lt_o = lt_i | (eq_i & ~a & b);
    end

endmodule

// File: rtl/comparator_4bit.sv
// Registered 4-bit unsigned magnitude comparator.
// Flags A_eq_B / A_gt_B / A_lt_B are one-hot after the first accepted sample
// and all zero after reset. Optional |A-B| output: define COMPARATOR_4BIT_DIFF_EN.
module comparator_4bit
    import comparator_4bit_pkg::*;
#(
    parameter int WIDTH = comparator_4bit_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    output logic             A_eq_B,
    output logic             A_gt_B,
    output logic             A_lt_B
`ifdef COMPARATOR_4BIT_DIFF_EN
    ,
    output logic [WIDTH-1:0] DIFF
`endif
);

    // Cascade taps: index WIDTH is the seed, index 0 is the final result.
    logic [WIDTH:0] eq_c;
    logic [WIDTH:0] gt_c;
    logic [WIDTH:0] lt_c;

    assign eq_c[WIDTH] = 1'b1;
    assign gt_c[WIDTH] = 1'b0;
    assign lt_c[WIDTH] = 1'b0;

    for (genvar i = WIDTH - 1; i >= 0; i--) begin : g_slice
        cmp_bit_slice u_slice (
            .a    (A[i]),
            .b    (B[i]),
            .eq_i (eq_c[i+1]),
            .gt_i (gt_c[i+1]),
            .lt_i (lt_c[i+1]),
            .eq_o (eq_c[i]),
            .gt_o (gt_c[i]),
            .lt_o (lt_c[i])
        );
    end

    cmp_result_t flags_d;
    cmp_result_t flags_q;
    logic        valid_d;
    logic        valid_q;

    // Capture a new result on an accepted sample, otherwise hold the last one.
    always_comb begin
        flags_d = flags_q;
        valid_d = in_valid;
        if (in_valid) begin
            flags_d = {lt_c[0], gt_c[0], eq_c[0]};
        end
    end

    // Output registers; reset wins over in_valid on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q <= CMP_NONE;
            valid_q <= 1'b0;
        end else begin
            flags_q <= flags_d;
            valid_q <= valid_d;
        end
    end

    assign out_valid = valid_q;
    assign A_eq_B    = flags_q[0];
    assign A_gt_B    = flags_q[1];
    assign A_lt_B    = flags_q[2];

`ifdef COMPARATOR_4BIT_DIFF_EN
    logic [WIDTH-1:0] diff_d;
    logic [WIDTH-1:0] diff_q;

    // Subtract the smaller operand from the larger so the result never wraps.
    always_comb begin
        diff_d = diff_q;
        if (in_valid) begin
            diff_d = lt_c[0] ? (B - A) : (A - B);
        end
    end

    // Magnitude register follows the same reset and hold rules as the flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            diff_q <= '0;
        end else begin
            diff_q <= diff_d;
        end
    end

    assign DIFF = diff_q;
`endif

endmodule

// File: tb/tb_comparator_4bit.sv
// Self-checking bench for comparator_4bit (optionally built with
// COMPARATOR_4BIT_DIFF_EN to cover the DIFF output).
module tb_comparator_4bit;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [3:0] A;
    logic [3:0] B;
    logic       out_valid;
    logic       A_eq_B;
    logic       A_gt_B;
    logic       A_lt_B;
    logic [3:0] diff_obs;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

`ifdef COMPARATOR_4BIT_DIFF_EN
    localparam bit DIFF_ON = 1'b1;
    logic [3:0] DIFF;
    assign diff_obs = DIFF;
`else
    localparam bit DIFF_ON = 1'b0;
    assign diff_obs = 4'd0;
`endif

    comparator_4bit dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .A_eq_B    (A_eq_B),
        .A_gt_B    (A_gt_B),
        .A_lt_B    (A_lt_B)
`ifdef COMPARATOR_4BIT_DIFF_EN
        ,
        .DIFF      (DIFF)
`endif
    );

    // Reference state: {valid, lt, gt, eq, diff}
    logic       exp_valid = 1'b0;
    logic [2:0] exp_flags = 3'b000;
    logic [3:0] exp_diff  = 4'd0;

    logic [7:0] obs_vec;
    logic [7:0] exp_vec;
    assign obs_vec = {out_valid, A_lt_B, A_gt_B, A_eq_B, diff_obs};
    assign exp_vec = {exp_valid, exp_flags, exp_diff};

    function automatic logic [3:0] dx(input int d);
        return DIFF_ON ? 4'(d) : 4'd0;
    endfunction

    // Drive one cycle and advance the model; returns 1 ns after the edge.
    task automatic drive(input logic r, input logic v, input int a, input int b);
        @(negedge clk);
        rst      = r;
        in_valid = v;
        A        = 4'(a);
        B        = 4'(b);
        if (r) begin
            exp_valid = 1'b0;
            exp_flags = 3'b000;
            exp_diff  = 4'd0;
        end else if (v) begin
            exp_valid = 1'b1;
            exp_flags = (a == b) ? 3'b001 : (a > b) ? 3'b010 : 3'b100;
            exp_diff  = dx((a >= b) ? a - b : b - a);
        end else begin
            exp_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b1, 7, 2);
        drive(1'b1, 1'b0, 0, 0);
        n_assert++;
        if (obs_vec !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_state: got %b want %b", obs_vec, 8'h00);
        end
    endtask

    task automatic test_directed();
        drive(1'b0, 1'b1, 0, 0);
        n_assert++;
        if (obs_vec !== {1'b1, 3'b001, dx(0)}) begin
            n_fail++;
            $display("FAIL eq_0_0: got %b want %b", obs_vec, {1'b1, 3'b001, dx(0)});
        end
        drive(1'b0, 1'b1, 5, 3);
        n_assert++;
        if (obs_vec !== {1'b1, 3'b010, dx(2)}) begin
            n_fail++;
            $display("FAIL gt_5_3: got %b want %b", obs_vec, {1'b1, 3'b010, dx(2)});
        end
        drive(1'b0, 1'b1, 10, 12);
        n_assert++;
        if (obs_vec !== {1'b1, 3'b100, dx(2)}) begin
            n_fail++;
            $display("FAIL lt_10_12: got %b want %b", obs_vec, {1'b1, 3'b100, dx(2)});
        end
        drive(1'b0, 1'b1, 15, 0);
        n_assert++;
        if (obs_vec !== {1'b1, 3'b010, dx(15)}) begin
            n_fail++;
            $display("FAIL gt_15_0: got %b want %b", obs_vec, {1'b1, 3'b010, dx(15)});
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b0, 1'b1, 15, 15);
        n_assert++;
        if (obs_vec !== {1'b1, 3'b001, dx(0)}) begin
            n_fail++;
            $display("FAIL b2b_eq_15_15: got %b want %b", obs_vec, {1'b1, 3'b001, dx(0)});
        end
        drive(1'b0, 1'b1, 0, 15);
        n_assert++;
        if (obs_vec !== {1'b1, 3'b100, dx(15)}) begin
            n_fail++;
            $display("FAIL b2b_lt_0_15: got %b want %b", obs_vec, {1'b1, 3'b100, dx(15)});
        end
    endtask

    task automatic test_hold();
        drive(1'b0, 1'b1, 9, 4);
        drive(1'b0, 1'b0, 0, 15);
        n_assert++;
        if (obs_vec !== {1'b0, 3'b010, dx(5)}) begin
            n_fail++;
            $display("FAIL hold_gt: got %b want %b", obs_vec, {1'b0, 3'b010, dx(5)});
        end
        drive(1'b0, 1'b0, 3, 3);
        n_assert++;
        if (obs_vec !== {1'b0, 3'b010, dx(5)}) begin
            n_fail++;
            $display("FAIL hold_gt_2: got %b want %b", obs_vec, {1'b0, 3'b010, dx(5)});
        end
    endtask

    task automatic test_reset_priority();
        drive(1'b0, 1'b1, 2, 8);
        drive(1'b1, 1'b1, 9, 3);
        n_assert++;
        if (obs_vec !== 8'h00) begin
            n_fail++;
            $display("FAIL rst_priority: got %b want %b", obs_vec, 8'h00);
        end
        drive(1'b0, 1'b0, 9, 3);
        n_assert++;
        if (obs_vec !== 8'h00) begin
            n_fail++;
            $display("FAIL rst_no_result: got %b want %b", obs_vec, 8'h00);
        end
    endtask

    task automatic test_sweep();
        int onehot_bad = 0;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                drive(1'b0, 1'b1, a, b);
                n_assert++;
                if (obs_vec !== exp_vec) begin
                    n_fail++;
                    $display("FAIL sweep A=%0d B=%0d: got %b want %b", a, b, obs_vec, exp_vec);
                end
                if ($countones({A_lt_B, A_gt_B, A_eq_B}) != 1) onehot_bad++;
            end
        end
        n_assert++;
        if (onehot_bad != 0) begin
            n_fail++;
            $display("FAIL sweep_onehot: got %0d bad results want 0", onehot_bad);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(0, 19) == 0), $urandom_range(0, 1) == 1,
                  int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
            n_assert++;
            if (obs_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL random step %0d: got %b want %b", i, obs_vec, exp_vec);
            end
        end
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        A        = 4'd0;
        B        = 4'd0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_hold();
        test_reset_priority();
        test_sweep();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
